stage_instruction_decode: RTL and testbench
===========================================

# stage_instruction_decode

Second pipeline stage of the five-stage RV32I core. Takes the fetched instruction word and its PC values, decodes opcode, funct fields and immediate, and reads the 32×32 register file. It also accepts register write-back from the WB stage. All results are registered into the `ex_*` pipeline register consumed by the execute stage, with stall and flush driven by the hazard unit.

## Interface
- No parameters; XLEN is fixed at 32.
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `de_instr`  in  32  instruction word from fetch/ROM
- `de_pc`, `de_pc_plus4`  in  32 each  PC and PC+4 of `de_instr`
- `ex_stall`, `ex_flush`  in  1 each  hazard-unit controls for the ex register
- `wb_reg_write`  in  1  write-back enable
- `wb_rd`  in  5  write-back destination
- `wb_result`  in  32  write-back data
- `de_rs1`, `de_rs2`  out  5 each  combinational source fields, for hazard detection
- `ex_rs1_data`, `ex_rs2_data`, `ex_imm`  out  32 each  operands and sign-extended immediate
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5 each  register indices, for forwarding
- `ex_pc`, `ex_pc_plus4`  out  32 each  forwarded PC values
- `ex_funct3`  out  3  branch condition / load-store size
- `ex_alu_ctrl`  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASS_B
- `ex_alu_src_a`  out  1  0 = rs1, 1 = PC
- `ex_alu_src_b`  out  1  0 = rs2, 1 = imm
- `ex_result_src`  out  2  00 ALU, 01 memory, 10 PC+4
- `ex_reg_write`, `ex_mem_write`, `ex_branch`, `ex_jump`, `ex_jalr`, `ex_illegal`  out  1 each  control flags

## Operation
- **Immediate formats**
  - I: `instr[31:20]`
  - S: `{instr[31:25], instr[11:7]}`
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`
  - U: `{instr[31:12], 12'b0}`
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`
  - I, S, B and J are sign-extended from bit 31; U is already 32 bits.
- **Opcodes decoded**
  - OP (0x33): funct7 bit 5 selects SUB/SRA.
  - OP-IMM (0x13): SRAI when `funct7[5]` = 1 and funct3 = 101.
  - LOAD (0x03): `result_src` = 01, ALU ADD.
  - STORE (0x23): `mem_write` = 1, `reg_write` = 0.
  - BRANCH (0x63): `branch` = 1, ALU SUB.
  - JAL (0x6F): `jump` = 1, `result_src` = 10.
  - JALR (0x67): `jump` = 1 and `jalr` = 1, ALU ADD of rs1 + imm.
  - LUI (0x37): PASS_B.
  - AUIPC (0x17): `alu_src_a` = 1, ADD.
- **Bubbles and illegal encodings**
  - Instruction `0x00000000` (flushed fetch) decodes as a bubble: every control flag is 0, including `ex_illegal`.
  - Any other unknown opcode: `ex_illegal` = 1 and all write/branch/jump flags = 0.
- **Register file**
  - 32 entries; x0 reads 0 and writes to x0 are ignored.
  - Written on the rising edge when `wb_reg_write` = 1.
  - Read combinationally by `de_rs1` / `de_rs2`.
  - Cleared to 0 on reset.
- **ex register priority** (highest first):
  1. reset: all `ex_*` = 0
  2. `ex_flush`: all `ex_*` = 0
  3. `ex_stall`: hold
  4. otherwise: load the decoded values
- Register-file writes are never blocked by stall or flush.

## Timing
- Latency: one cycle. A `de_instr` present at edge N appears on `ex_*` after edge N.
- `de_rs1`/`de_rs2` are purely combinational from `de_instr`, valid in the same cycle.
- Reset value of every output register is 0; `de_rs*` follow `de_instr`.
- `ex_flush` together with `ex_stall`: flush wins.
- Reset asserted mid-stall: reset wins, and the register file is cleared in the same edge.
- Write-back to rd = x0: no state change.

## Configuration
- **`DECODE_WB_BYPASS_EN` defined:** a write-back in the same cycle to a register being read supplies `wb_result` directly. Condition: `wb_reg_write` = 1, `wb_rd` = `de_rs*` and `wb_rd` ≠ 0. No extra stall is needed.
- **Not defined:** reads return the pre-write contents. The hazard unit must then stall decode one extra cycle on that WB→DE dependency.

## Test plan
- `rst_n` = 0 for 2 cycles with `de_instr` = `0x00A00093` → all `ex_*` = 0; then x1..x31 read 0.
- `addi x1,x0,10` (`0x00A00093`) → after 1 edge: `ex_imm` = 10, `ex_rd` = 1, `ex_alu_src_b` = 1, `ex_reg_write` = 1, `ex_alu_ctrl` = 0.
- Write-back x5 = `0xDEADBEEF`, and in the same cycle decode `add x6,x5,x5` → `ex_rs1_data` = `0xDEADBEEF` with the macro defined; 0 without it.
- `beq` with offset −4 (`0xFE000EE3`) → `ex_imm` = `0xFFFFFFFC`, `ex_branch` = 1, `ex_alu_ctrl` = 1, `ex_reg_write` = 0.
- Load `0x12345037` (LUI) while `ex_stall` = 1 for 2 cycles → `ex_*` hold the previous value. Then assert `ex_flush` and `ex_stall` together → `ex_*` = 0.
- Opcode `0x7F`, then `0x00000000` → `ex_illegal` = 1 for the first, 0 for the second, and all write flags = 0 for both.

Source files
------------

// File: rtl/stage_instruction_decode.sv
// rtl/stage_instruction_decode.sv - RV32I decode stage: field/immediate decode, 32x32 register file, ex pipeline register
// Optional macro DECODE_WB_BYPASS_EN forwards a same-cycle write-back into the register read path.
module stage_instruction_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] de_instr,
  input  logic [31:0] de_pc,
  input  logic [31:0] de_pc_plus4,
  input  logic        ex_stall,
  input  logic        ex_flush,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic [4:0]  de_rs1,
  output logic [4:0]  de_rs2,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_pc_plus4,
  output logic [2:0]  ex_funct3,
  output logic [3:0]  ex_alu_ctrl,
  output logic        ex_alu_src_a,
  output logic        ex_alu_src_b,
  output logic [1:0]  ex_result_src,
  output logic        ex_reg_write,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_jalr,
  output logic        ex_illegal
);

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLTU   = 4'd6;
  localparam logic [3:0] ALU_SLL    = 4'd7;
  localparam logic [3:0] ALU_SRL    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [4:0]  rd;

  assign opcode    = de_instr[6:0];
  assign funct3    = de_instr[14:12];
  assign funct7_b5 = de_instr[30];
  assign rd        = de_instr[11:7];
  assign de_rs1    = de_instr[19:15];
  assign de_rs2    = de_instr[24:20];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{de_instr[31]}}, de_instr[31:20]};
  assign imm_s = {{20{de_instr[31]}}, de_instr[31:25], de_instr[11:7]};
  assign imm_b = {{19{de_instr[31]}}, de_instr[31], de_instr[7], de_instr[30:25], de_instr[11:8], 1'b0};
  assign imm_u = {de_instr[31:12], 12'b0};
  assign imm_j = {{11{de_instr[31]}}, de_instr[31], de_instr[19:12], de_instr[20], de_instr[30:21], 1'b0};

  // Register file; x0 is never written so it stays at its reset value of 0.
  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wb_reg_write && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_result;
    end
  end

  logic [31:0] rs1_data, rs2_data;

  always_comb begin
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    if (de_rs1 != 5'd0) rs1_data = regs[de_rs1];
    if (de_rs2 != 5'd0) rs2_data = regs[de_rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == de_rs1)) rs1_data = wb_result;
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == de_rs2)) rs2_data = wb_result;
`endif
  end

  // Shared R/I-type ALU op mapping; SUB only exists for the register form.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic b5, input logic allow_sub);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (b5 && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [31:0] d_imm;
  logic [3:0]  d_alu_ctrl;
  logic        d_alu_src_a, d_alu_src_b;
  logic [1:0]  d_result_src;
  logic        d_reg_write, d_mem_write, d_branch, d_jump, d_jalr, d_illegal;

  always_comb begin
    d_imm        = 32'd0;
    d_alu_ctrl   = ALU_ADD;
    d_alu_src_a  = 1'b0;
    d_alu_src_b  = 1'b0;
    d_result_src = 2'b00;
    d_reg_write  = 1'b0;
    d_mem_write  = 1'b0;
    d_branch     = 1'b0;
    d_jump       = 1'b0;
    d_jalr       = 1'b0;
    d_illegal    = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_alu_ctrl  = alu_op(funct3, funct7_b5, 1'b1);
        d_reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        d_imm       = imm_i;
        d_alu_ctrl  = alu_op(funct3, funct7_b5, 1'b0);
        d_alu_src_b = 1'b1;
        d_reg_write = 1'b1;
      end
      OPC_LOAD: begin
        d_imm        = imm_i;
        d_alu_src_b  = 1'b1;
        d_result_src = 2'b01;
        d_reg_write  = 1'b1;
      end
      OPC_STORE: begin
        d_imm       = imm_s;
        d_alu_src_b = 1'b1;
        d_mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        d_imm      = imm_b;
        d_alu_ctrl = ALU_SUB;
        d_branch   = 1'b1;
      end
      OPC_JAL: begin
        d_imm        = imm_j;
        d_alu_src_a  = 1'b1;
        d_alu_src_b  = 1'b1;
        d_result_src = 2'b10;
        d_reg_write  = 1'b1;
        d_jump       = 1'b1;
      end
      OPC_JALR: begin
        d_imm        = imm_i;
        d_alu_src_b  = 1'b1;
        d_result_src = 2'b10;
        d_reg_write  = 1'b1;
        d_jump       = 1'b1;
        d_jalr       = 1'b1;
      end
      OPC_LUI: begin
        d_imm       = imm_u;
        d_alu_ctrl  = ALU_PASS_B;
        d_alu_src_b = 1'b1;
        d_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        d_imm       = imm_u;
        d_alu_src_a = 1'b1;
        d_alu_src_b = 1'b1;
        d_reg_write = 1'b1;
      end
      default: begin
        // An all-zero word is a flushed fetch and must look like a clean bubble.
        d_illegal = (de_instr != 32'd0);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || ex_flush) begin
      ex_rs1_data   <= 32'd0;
      ex_rs2_data   <= 32'd0;
      ex_imm        <= 32'd0;
      ex_rs1        <= 5'd0;
      ex_rs2        <= 5'd0;
      ex_rd         <= 5'd0;
      ex_pc         <= 32'd0;
      ex_pc_plus4   <= 32'd0;
      ex_funct3     <= 3'd0;
      ex_alu_ctrl   <= 4'd0;
      ex_alu_src_a  <= 1'b0;
      ex_alu_src_b  <= 1'b0;
      ex_result_src <= 2'd0;
      ex_reg_write  <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_jalr       <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (!ex_stall) begin
      ex_rs1_data   <= rs1_data;
      ex_rs2_data   <= rs2_data;
      ex_imm        <= d_imm;
      ex_rs1        <= de_rs1;
      ex_rs2        <= de_rs2;
      ex_rd         <= rd;
      ex_pc         <= de_pc;
      ex_pc_plus4   <= de_pc_plus4;
      ex_funct3     <= funct3;
      ex_alu_ctrl   <= d_alu_ctrl;
      ex_alu_src_a  <= d_alu_src_a;
      ex_alu_src_b  <= d_alu_src_b;
      ex_result_src <= d_result_src;
      ex_reg_write  <= d_reg_write;
      ex_mem_write  <= d_mem_write;
      ex_branch     <= d_branch;
      ex_jump       <= d_jump;
      ex_jalr       <= d_jalr;
      ex_illegal    <= d_illegal;
    end
  end

endmodule

// File: tb/tb_stage_instruction_decode.sv
// tb/tb_stage_instruction_decode.sv - directed self-checking bench for stage_instruction_decode
module tb_stage_instruction_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] de_instr, de_pc, de_pc_plus4;
  logic        ex_stall, ex_flush;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic [4:0]  de_rs1, de_rs2;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_pc, ex_pc_plus4;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_ctrl;
  logic        ex_alu_src_a, ex_alu_src_b;
  logic [1:0]  ex_result_src;
  logic        ex_reg_write, ex_mem_write, ex_branch, ex_jump, ex_jalr, ex_illegal;

  int errors = 0;
  int checks = 0;

  stage_instruction_decode dut (
    .clk(clk), .rst_n(rst_n), .de_instr(de_instr), .de_pc(de_pc), .de_pc_plus4(de_pc_plus4),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .de_rs1(de_rs1), .de_rs2(de_rs2), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4), .ex_funct3(ex_funct3), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_alu_src_a(ex_alu_src_a), .ex_alu_src_b(ex_alu_src_b), .ex_result_src(ex_result_src),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; de_instr = 32'd0; de_pc = 32'd0; de_pc_plus4 = 32'd0;
    ex_stall = 1'b0; ex_flush = 1'b0; wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
    step(); step();
    rst_n = 1'b1;
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'h55;
    step();
    wb_reg_write = 1'b0;
    rst_n = 1'b0; ex_stall = 1'b1;
    de_instr = 32'h00A00093; de_pc = 32'h100; de_pc_plus4 = 32'h104;
    step(); step();
    checks++; if (de_rs2 !== 5'd10) begin errors++; $display("FAIL reset_de_rs2 got %0d exp 10", de_rs2); end
    checks++; if (ex_imm !== 32'd0) begin errors++; $display("FAIL reset_ex_imm got %h exp 0", ex_imm); end
    checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_ex_rd got %0d exp 0", ex_rd); end
    checks++; if (ex_pc !== 32'd0) begin errors++; $display("FAIL reset_ex_pc got %h exp 0", ex_pc); end
    checks++; if ({ex_reg_write, ex_alu_src_b, ex_alu_ctrl} !== 6'd0) begin errors++; $display("FAIL reset_ctrl got %b exp 0", {ex_reg_write, ex_alu_src_b, ex_alu_ctrl}); end
    rst_n = 1'b1; ex_stall = 1'b0;
    for (int i = 1; i < 32; i++) begin
      de_instr = {7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'h33};
      step();
      checks++; if (ex_rs1_data !== 32'd0 || ex_rs2_data !== 32'd0) begin errors++; $display("FAIL reset_regfile x%0d got %h/%h exp 0", i, ex_rs1_data, ex_rs2_data); end
    end
  endtask

  task automatic test_addi();
    de_instr = 32'h00A00093; de_pc = 32'h100; de_pc_plus4 = 32'h104;
    step();
    checks++; if (ex_imm !== 32'd10) begin errors++; $display("FAIL addi_imm got %h exp a", ex_imm); end
    checks++; if (ex_rd !== 5'd1) begin errors++; $display("FAIL addi_rd got %0d exp 1", ex_rd); end
    checks++; if ({ex_alu_src_b, ex_reg_write, ex_alu_ctrl} !== 6'b110000) begin errors++; $display("FAIL addi_ctrl got %b exp 110000", {ex_alu_src_b, ex_reg_write, ex_alu_ctrl}); end
    checks++; if (ex_pc !== 32'h100 || ex_pc_plus4 !== 32'h104) begin errors++; $display("FAIL addi_pc got %h/%h exp 100/104", ex_pc, ex_pc_plus4); end
  endtask

  task automatic test_writeback();
    logic [31:0] exp_bypass;
`ifdef DECODE_WB_BYPASS_EN
    exp_bypass = 32'hDEADBEEF;
`else
    exp_bypass = 32'd0;
`endif
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_result = 32'hDEADBEEF;
    de_instr = 32'h00528333;
    step();
    checks++; if (ex_rs1_data !== exp_bypass) begin errors++; $display("FAIL wb_same_cycle got %h exp %h", ex_rs1_data, exp_bypass); end
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'h1234;
    de_instr = 32'h405283B3;
    step();
    checks++; if (ex_rs1_data !== 32'hDEADBEEF || ex_rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_after got %h/%h exp deadbeef", ex_rs1_data, ex_rs2_data); end
    checks++; if (ex_alu_ctrl !== 4'd1 || ex_rd !== 5'd7 || ex_alu_src_b !== 1'b0) begin errors++; $display("FAIL sub_ctrl got %0d rd %0d exp 1 rd 7", ex_alu_ctrl, ex_rd); end
    wb_reg_write = 1'b0;
    de_instr = 32'h00000333;
    step();
    checks++; if (ex_rs1_data !== 32'd0) begin errors++; $display("FAIL wb_x0 got %h exp 0", ex_rs1_data); end
  endtask

  task automatic test_formats();
    de_instr = 32'hFE000EE3; step();
    checks++; if (ex_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm got %h exp fffffffc", ex_imm); end
    checks++; if ({ex_branch, ex_reg_write, ex_alu_ctrl} !== 6'b100001) begin errors++; $display("FAIL beq_ctrl got %b exp 100001", {ex_branch, ex_reg_write, ex_alu_ctrl}); end
    de_instr = 32'h40315093; step();
    checks++; if (ex_alu_ctrl !== 4'd9 || ex_imm !== 32'h403) begin errors++; $display("FAIL srai got %0d imm %h exp 9 imm 403", ex_alu_ctrl, ex_imm); end
    de_instr = 32'h008000EF; step();
    checks++; if (ex_imm !== 32'd8 || {ex_jump, ex_jalr, ex_reg_write, ex_result_src} !== 5'b10110) begin errors++; $display("FAIL jal got imm %h flags %b exp 8 10110", ex_imm, {ex_jump, ex_jalr, ex_reg_write, ex_result_src}); end
    de_instr = 32'h0020A223; step();
    checks++; if (ex_imm !== 32'd4 || {ex_mem_write, ex_reg_write} !== 2'b10 || ex_funct3 !== 3'd2) begin errors++; $display("FAIL sw got imm %h flags %b f3 %0d exp 4 10 2", ex_imm, {ex_mem_write, ex_reg_write}, ex_funct3); end
    de_instr = 32'hFFF02083; step();
    checks++; if (ex_imm !== 32'hFFFFFFFF || ex_result_src !== 2'b01 || ex_alu_ctrl !== 4'd0) begin errors++; $display("FAIL lw got imm %h rs %b exp ffffffff 01", ex_imm, ex_result_src); end
  endtask

  task automatic test_stall_flush();
    de_instr = 32'hFE000EE3; step();
    de_instr = 32'h12345037; ex_stall = 1'b1;
    step(); step();
    checks++; if (ex_imm !== 32'hFFFFFFFC || ex_branch !== 1'b1 || ex_alu_ctrl !== 4'd1) begin errors++; $display("FAIL stall_hold got imm %h br %b exp fffffffc 1", ex_imm, ex_branch); end
    ex_stall = 1'b0; step();
    checks++; if (ex_imm !== 32'h12345000 || ex_alu_ctrl !== 4'd10 || ex_branch !== 1'b0) begin errors++; $display("FAIL lui got imm %h alu %0d exp 12345000 10", ex_imm, ex_alu_ctrl); end
    ex_stall = 1'b1; ex_flush = 1'b1; step();
    checks++; if (ex_imm !== 32'd0 || ex_alu_ctrl !== 4'd0 || ex_reg_write !== 1'b0 || ex_alu_src_b !== 1'b0) begin errors++; $display("FAIL flush_over_stall got imm %h alu %0d exp 0", ex_imm, ex_alu_ctrl); end
    ex_stall = 1'b0; ex_flush = 1'b0;
  endtask

  task automatic test_illegal();
    de_instr = 32'h0000007F; step();
    checks++; if ({ex_illegal, ex_reg_write, ex_mem_write, ex_branch, ex_jump} !== 5'b10000) begin errors++; $display("FAIL illegal_7f got %b exp 10000", {ex_illegal, ex_reg_write, ex_mem_write, ex_branch, ex_jump}); end
    de_instr = 32'h00000000; step();
    checks++; if ({ex_illegal, ex_reg_write, ex_mem_write, ex_branch, ex_jump} !== 5'b00000) begin errors++; $display("FAIL bubble got %b exp 00000", {ex_illegal, ex_reg_write, ex_mem_write, ex_branch, ex_jump}); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_writeback();
    test_formats();
    test_stall_flush();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
